// File: rtl/cv32e40x_alu_result_buf.sv
// Two-entry registered skid buffer between the ALU (EX) and WB.
// Every output is decoded from flops, so neither handshake side sees a combinational path from the other.
module cv32e40x_alu_result_buf #(
  parameter int RESULT_W  = 32,
  parameter int RD_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [RESULT_W-1:0]  in_result_i,
  input  logic                 in_cmp_i,
  input  logic [RD_ADDR_W-1:0] in_rd_addr_i,
  input  logic                 in_rd_we_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [RESULT_W-1:0]  out_result_o,
  output logic                 out_cmp_o,
  output logic [RD_ADDR_W-1:0] out_rd_addr_o,
  output logic                 out_rd_we_o,
  output logic [1:0]           occupancy_o
);

  typedef struct packed {
    logic [RESULT_W-1:0]  result;
    logic                 cmp;
    logic [RD_ADDR_W-1:0] rd_addr;
    logic                 rd_we;
  } entry_t;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state, state_n;
  entry_t entry0, entry1, entry0_n, entry1_n;
  entry_t in_entry;
  logic   push, pop;

  assign in_entry    = '{result: in_result_i, cmp: in_cmp_i, rd_addr: in_rd_addr_i, rd_we: in_rd_we_i};

  assign in_ready_o  = (state != FULL);
  assign out_valid_o = (state != EMPTY);
  assign occupancy_o = state;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  // Head payload is forced to zero while nothing is valid.
  assign out_result_o  = out_valid_o ? entry0.result  : '0;
  assign out_cmp_o     = out_valid_o ? entry0.cmp     : 1'b0;
  assign out_rd_addr_o = out_valid_o ? entry0.rd_addr : '0;
  assign out_rd_we_o   = out_valid_o ? entry0.rd_we   : 1'b0;

  always_comb begin
    state_n  = state;
    entry0_n = entry0;
    entry1_n = entry1;
    if (flush_i) begin
      // A pop this cycle still counts as a transfer; WB handles its own kill.
      state_n  = EMPTY;
      entry0_n = '0;
      entry1_n = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_n  = ONE;
            entry0_n = in_entry;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_n  = FULL;
            entry1_n = in_entry;
          end else if (pop && !push) begin
            state_n  = EMPTY;
            entry0_n = '0;
          end else if (push && pop) begin
            entry0_n = in_entry;
          end
        end
        FULL: begin
          if (pop) begin
            state_n  = ONE;
            entry0_n = entry1;
            entry1_n = '0;
          end
        end
        default: begin
          state_n  = EMPTY;
          entry0_n = '0;
          entry1_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      assert (!(push && state == FULL)) else $error("push while FULL");
      assert (!(pop && state == EMPTY)) else $error("pop while EMPTY");
      state  <= state_n;
      entry0 <= entry0_n;
      entry1 <= entry1_n;
    end
  end

endmodule

// File: tb/tb_cv32e40x_alu_result_buf.sv
// Directed scenarios plus a randomized run checked against a queue model of the buffer.
module tb_cv32e40x_alu_result_buf;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_cmp, in_rd_we;
  logic [31:0] in_result;
  logic [4:0]  in_rd_addr;
  logic        out_valid, out_ready, out_cmp, out_rd_we;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef logic [38:0] ent_t; // {result, cmp, rd_addr, rd_we}
  ent_t q[$];

  always #5 clk = ~clk;

  cv32e40x_alu_result_buf #(.RESULT_W(32), .RD_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_result_i(in_result), .in_cmp_i(in_cmp),
    .in_rd_addr_i(in_rd_addr), .in_rd_we_i(in_rd_we),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_cmp_o(out_cmp),
    .out_rd_addr_o(out_rd_addr), .out_rd_we_o(out_rd_we),
    .occupancy_o(occupancy)
  );

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd);
    in_valid   = v;
    in_result  = res;
    in_cmp     = res[0];
    in_rd_addr = rd;
    in_rd_we   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, occupancy, in_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset[%0d]: valid/occ/ready=%b expected 0001", i, {out_valid, occupancy, in_ready});
      end
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy, in_ready, out_result} !== {4'b0001, 32'h0}) begin
      errors++;
      $display("FAIL reset_idle: valid/occ/ready=%b result=%h expected 0001/0", {out_valid, occupancy, in_ready}, out_result);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals[3] = '{32'h11, 32'h22, 32'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 5'(i + 1));
      @(negedge clk);
      checks++;
      if ({out_valid, occupancy, out_result, out_rd_addr} !== {1'b1, 2'd1, vals[i], 5'(i + 1)}) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b occ=%0d result=%h rd=%0d expected 1/1/%h/%0d",
                 i, out_valid, occupancy, out_result, out_rd_addr, vals[i], i + 1);
      end
    end
    drive(1'b0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++;
      $display("FAIL stream_drain: valid=%b occ=%0d expected 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd5);
    @(negedge clk);
    drive(1'b1, 32'hB, 5'd6);
    @(negedge clk);
    checks++;
    if ({occupancy, in_ready, out_result, out_rd_addr} !== {2'd2, 1'b0, 32'hA, 5'd5}) begin
      errors++;
      $display("FAIL bp_full: occ=%0d ready=%b result=%h rd=%0d expected 2/0/a/5", occupancy, in_ready, out_result, out_rd_addr);
    end
    drive(1'b0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy, out_result, out_rd_addr} !== {1'b1, 2'd2, 32'hA, 5'd5}) begin
      errors++;
      $display("FAIL bp_hold: valid=%b occ=%0d result=%h rd=%0d expected 1/2/a/5", out_valid, occupancy, out_result, out_rd_addr);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({occupancy, in_ready, out_result, out_rd_addr} !== {2'd1, 1'b1, 32'hB, 5'd6}) begin
      errors++;
      $display("FAIL bp_pop1: occ=%0d ready=%b result=%h rd=%0d expected 1/1/b/6", occupancy, in_ready, out_result, out_rd_addr);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy, out_result} !== {1'b0, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL bp_pop2: valid=%b occ=%0d result=%h expected 0/0/0", out_valid, occupancy, out_result);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd1);
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 32'h2, 5'd2);
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy, out_result, out_rd_addr} !== {1'b1, 2'd1, 32'h2, 5'd2}) begin
      errors++;
      $display("FAIL simul: valid=%b occ=%0d result=%h rd=%0d expected 1/1/2/2", out_valid, occupancy, out_result, out_rd_addr);
    end
    drive(1'b0, 32'h0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 5'd7);
    @(negedge clk);
    drive(1'b1, 32'h200, 5'd8);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 5'd9);
    @(negedge clk);
    checks++;
    if ({out_valid, occupancy, in_ready, out_result} !== {4'b0001, 32'h0}) begin
      errors++;
      $display("FAIL flush: valid/occ/ready=%b result=%h expected 0001/0", {out_valid, occupancy, in_ready}, out_result);
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_result === 32'hDEAD) begin
        errors++;
        $display("FAIL flush_drop[%0d]: valid=%b result=%h expected 0/not dead", i, out_valid, out_result);
      end
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 5'd10);
    @(negedge clk);
    drive(1'b1, 32'h88, 5'd11);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, occupancy, in_ready, out_result, out_cmp, out_rd_addr, out_rd_we} !== {4'b0001, 39'h0}) begin
      errors++;
      $display("FAIL mid_reset: valid/occ/ready=%b result=%h cmp=%b rd=%0d we=%b expected 0001/0",
               {out_valid, occupancy, in_ready}, out_result, out_cmp, out_rd_addr, out_rd_we);
    end
  endtask

  // Reference: the buffer is a FIFO of depth 2; outputs show its head.
  task automatic test_random();
    ent_t exp_head;
    logic push, pop;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_head = (q.size() != 0) ? q[0] : '0;
      checks++;
      if ({out_valid, occupancy, in_ready} !== {q.size() != 0, 2'(q.size()), q.size() < 2} ||
          {out_result, out_cmp, out_rd_addr, out_rd_we} !== exp_head) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b occ=%0d ready=%b head=%h expected occ=%0d head=%h",
                 cyc, out_valid, occupancy, in_ready, {out_result, out_cmp, out_rd_addr, out_rd_we},
                 q.size(), exp_head);
      end
      rst        = ($urandom_range(99) < 2);
      flush      = ($urandom_range(99) < 5);
      in_valid   = ($urandom_range(99) < 65);
      out_ready  = ($urandom_range(99) < 55);
      in_result  = $urandom;
      in_cmp     = 1'($urandom);
      in_rd_addr = 5'($urandom);
      in_rd_we   = 1'($urandom);
      pop  = (q.size() != 0) && out_ready;
      push = in_valid && (q.size() < 2) && !flush;
      if (rst) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        else if (push) q.push_back({in_result, in_cmp, in_rd_addr, in_rd_we});
      end
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_simultaneous();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
